shifter_32: RTL and testbench

SHIFTER_32 -- requirements
Module: shifter_32

---
 rtl/shifter_32.sv | 84 ++++++++
 tb/tb_shifter_32.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/shifter_32.sv
// Registered 32-bit barrel shifter: SLL/SRL/SRA (and ROTR on op=11 when
// SHIFTER_32_ROTATE_EN is defined; otherwise op=11 aliases SLL), 1-cycle latency.
module shifter_32 #(
    parameter int unsigned DEFAULT_SHAMT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Data_in,
    input  logic        in_valid,
    input  logic [1:0]  op,
    input  logic [4:0]  shamt,
    input  logic        use_shamt,
    output logic [31:0] Data_out,
    output logic        out_valid
);

    localparam logic [4:0] DefaultK = 5'(DEFAULT_SHAMT);

    typedef enum logic [1:0] {
        OpSll  = 2'b00,
        OpSrl  = 2'b01,
        OpSra  = 2'b10,
        OpRotr = 2'b11
    } op_e;

    function automatic logic [31:0] rev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = x[31-i];
        end
        return r;
    endfunction

    logic [4:0]  k;
    logic        is_left;
    logic        fill_bit;
    logic [31:0] stage [6];
    logic [31:0] result;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;

    always_comb begin
        k        = use_shamt ? shamt : DefaultK;
        fill_bit = (op_e'(op) == OpSra) & Data_in[31];
`ifdef SHIFTER_32_ROTATE_EN
        is_left  = (op_e'(op) == OpSll);
`else
        is_left  = (op_e'(op) == OpSll) | (op_e'(op) == OpRotr);
`endif
        // Left shifts run through the right-shift network on bit-reversed data.
        stage[0] = is_left ? rev32(Data_in) : Data_in;
        result   = is_left ? rev32(stage[5]) : stage[5];
    end

    for (genvar i = 0; i < 5; i++) begin : g_stage
        localparam int unsigned S = 1 << i;
        logic [S-1:0] fill_bits;
`ifdef SHIFTER_32_ROTATE_EN
        assign fill_bits = (op_e'(op) == OpRotr) ? stage[i][S-1:0] : {S{fill_bit}};
`else
        assign fill_bits = {S{fill_bit}};
`endif
        assign stage[i+1] = k[i] ? {fill_bits, stage[i][31:S]} : stage[i];
    end

    always_comb begin
        valid_d = in_valid;
        data_d  = in_valid ? result : data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign Data_out  = data_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_shifter_32.sv
// Directed self-checking bench for shifter_32; rotate expectation follows
// whether SHIFTER_32_ROTATE_EN is defined.
module tb_shifter_32;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Data_in;
    logic        in_valid;
    logic [1:0]  op;
    logic [4:0]  shamt;
    logic        use_shamt;
    logic [31:0] Data_out;
    logic        out_valid;

    int tests = 0;
    int fails = 0;

    shifter_32 #(.DEFAULT_SHAMT(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .Data_in   (Data_in),
        .in_valid  (in_valid),
        .op        (op),
        .shamt     (shamt),
        .use_shamt (use_shamt),
        .Data_out  (Data_out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [1:0] o, input logic [4:0] s,
                         input logic u, input logic [31:0] d);
        in_valid  = v;
        op        = o;
        shamt     = s;
        use_shamt = u;
        Data_in   = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 2'b00, 5'd0, 1'b0, 32'h0);
        step();
        step();
        tests++;
        if (Data_out !== 32'h0000_0000) begin
            fails++;
            $display("FAIL reset_data: got %h want 00000000", Data_out);
        end
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_valid: got %b want 0", out_valid);
        end
        reset = 1'b0;
        drive(1'b1, 2'b00, 5'd0, 1'b0, 32'd5);
        step();
        tests++;
        if (Data_out !== 32'h0000_0014) begin
            fails++;
            $display("FAIL default_shamt_data: got %h want 00000014", Data_out);
        end
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL default_shamt_valid: got %b want 1", out_valid);
        end
    endtask

    task automatic test_right_shifts();
        drive(1'b1, 2'b10, 5'd4, 1'b1, 32'h8000_0000);
        step();
        tests++;
        if (Data_out !== 32'hF800_0000 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL sra: got %h/%b want f8000000/1", Data_out, out_valid);
        end
        drive(1'b1, 2'b01, 5'd4, 1'b1, 32'h8000_0000);
        step();
        tests++;
        if (Data_out !== 32'h0800_0000 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL srl: got %h/%b want 08000000/1", Data_out, out_valid);
        end
        drive(1'b1, 2'b10, 5'd4, 1'b1, 32'h7000_0000);
        step();
        tests++;
        if (Data_out !== 32'h0700_0000) begin
            fails++;
            $display("FAIL sra_positive: got %h want 07000000", Data_out);
        end
    endtask

    task automatic test_rotate();
        logic [31:0] exp;
`ifdef SHIFTER_32_ROTATE_EN
        exp = 32'h7812_3456;
`else
        exp = 32'h3456_7800;
`endif
        drive(1'b1, 2'b11, 5'd8, 1'b1, 32'h1234_5678);
        step();
        tests++;
        if (Data_out !== exp) begin
            fails++;
            $display("FAIL op11: got %h want %h", Data_out, exp);
        end
    endtask

    task automatic test_boundaries();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'(i), 5'd0, 1'b1, 32'hDEAD_BEEF);
            step();
            tests++;
            if (Data_out !== 32'hDEAD_BEEF) begin
                fails++;
                $display("FAIL zero_shift_op%0d: got %h want deadbeef", i, Data_out);
            end
        end
        drive(1'b1, 2'b00, 5'd31, 1'b1, 32'hDEAD_BEEF);
        step();
        tests++;
        if (Data_out !== 32'h8000_0000) begin
            fails++;
            $display("FAIL sll31: got %h want 80000000", Data_out);
        end
        drive(1'b1, 2'b10, 5'd31, 1'b1, 32'h8000_0000);
        step();
        tests++;
        if (Data_out !== 32'hFFFF_FFFF) begin
            fails++;
            $display("FAIL sra31: got %h want ffffffff", Data_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] din  [3];
        logic [1:0]  ops  [3];
        logic [4:0]  sh   [3];
        logic [31:0] exp  [3];
        din[0] = 32'h0000_0001; ops[0] = 2'b00; sh[0] = 5'd4; exp[0] = 32'h0000_0010;
        din[1] = 32'hF000_0000; ops[1] = 2'b10; sh[1] = 5'd8; exp[1] = 32'hFFF0_0000;
        din[2] = 32'h0000_FF00; ops[2] = 2'b01; sh[2] = 5'd8; exp[2] = 32'h0000_00FF;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ops[i], sh[i], 1'b1, din[i]);
            step();
            tests++;
            if (Data_out !== exp[i] || out_valid !== 1'b1) begin
                fails++;
                $display("FAIL b2b_%0d: got %h/%b want %h/1", i, Data_out, out_valid, exp[i]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 2'b00, 5'd1, 1'b1, 32'h1111_1111);
            step();
            tests++;
            if (Data_out !== 32'h0000_00FF || out_valid !== 1'b0) begin
                fails++;
                $display("FAIL idle_hold_%0d: got %h/%b want 000000ff/0", i, Data_out,
                         out_valid);
            end
        end
    endtask

    task automatic test_reset_drop();
        reset = 1'b1;
        drive(1'b1, 2'b00, 5'd1, 1'b1, 32'h0000_0003);
        step();
        tests++;
        if (Data_out !== 32'h0000_0000 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_drop: got %h/%b want 00000000/0", Data_out, out_valid);
        end
        reset = 1'b0;
        drive(1'b1, 2'b00, 5'd1, 1'b1, 32'h0000_0003);
        step();
        tests++;
        if (Data_out !== 32'h0000_0006 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL resume: got %h/%b want 00000006/1", Data_out, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_right_shifts();
        test_rotate();
        test_boundaries();
        test_back_to_back();
        test_reset_drop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
